// File: rtl/toggle_strobe_gen.sv
// Strobe generator feeding a downstream T flip-flop: holds enable high and issues
// one-cycle T pulses every div+1 clocks, for a programmed burst or continuously.
module toggle_strobe_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] burst,
  output logic             enable,
  output logic             T,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] strobe_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] pc, pc_n, div_l, div_l_n;
  logic [CNT_W-1:0] burst_l, burst_l_n, cnt_n, cnt_inc;
  logic             enable_n, t_n, busy_n, done_n;

  assign cnt_inc = strobe_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= '0;
      div_l      <= '0;
      burst_l    <= '0;
      strobe_cnt <= '0;
      enable     <= 1'b0;
      T          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      div_l      <= div_l_n;
      burst_l    <= burst_l_n;
      strobe_cnt <= cnt_n;
      enable     <= enable_n;
      T          <= t_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    div_l_n   = div_l;
    burst_l_n = burst_l;
    cnt_n     = strobe_cnt;
    enable_n  = enable;
    t_n       = 1'b0;
    busy_n    = busy;
    done_n    = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          div_l_n   = div;
          burst_l_n = burst;
          pc_n      = '0;
          cnt_n     = '0;
          enable_n  = 1'b1;
          busy_n    = 1'b1;
          state_n   = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          pc_n     = '0;
          enable_n = 1'b0;
          busy_n   = 1'b0;
          state_n  = IDLE;
        end else if (pc == div_l) begin
          pc_n  = '0;
          t_n   = 1'b1;
          cnt_n = cnt_inc;
          // The final pulse gets one extra cycle in LAST so the flop sees it with enable high
          if (burst_l != '0 && cnt_inc == burst_l) state_n = LAST;
        end else begin
          pc_n = pc + DIV_W'(1);
        end
      end
      LAST: begin
        pc_n     = '0;
        enable_n = 1'b0;
        busy_n   = 1'b0;
        done_n   = !abort;
        state_n  = IDLE;
      end
      default: begin
        pc_n     = '0;
        enable_n = 1'b0;
        busy_n   = 1'b0;
        state_n  = IDLE;
      end
    endcase
  end

endmodule

// File: doc/toggle_strobe_gen.md
Name: toggle_strobe_gen

Overview:
- Programmable strobe generator that sits directly upstream of the T flip-flop stage and drives its enable and T inputs.
- On start it asserts enable and issues single-cycle T pulses every DIV+1 clocks.
- It stops after a programmed burst count, or runs continuously, and reports busy, done and a pulse count.
- The downstream Q output therefore toggles a known number of times at a known rate.

Parameters:
DIV_W, 8, width of the prescale divider input and the internal prescale counter
CNT_W, 8, width of the burst length input and the strobe counter

Ports:
clk  input  1  single system clock; everything samples on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request to begin a burst; sampled only in IDLE
abort  input  1  terminates an active burst; sampled in RUN and LAST
div  input  DIV_W  pulse period minus one, in clocks; latched on accepted start
burst  input  CNT_W  number of T pulses; 0 means continuous; latched on accepted start
enable  output  1  enable for the downstream T flip-flop; registered
T  output  1  toggle pulse to the downstream T flip-flop; registered, one cycle wide
busy  output  1  high while a burst is active (RUN or LAST)
done  output  1  one-cycle pulse on normal burst completion
strobe_cnt  output  CNT_W  T pulses issued since the last accepted start

Behaviour:
- Reset (asynchronous, active-high): state=IDLE. enable, T, busy, done, strobe_cnt, prescale counter pc, div_l and burst_l all clear to 0 immediately, with no clock edge required.
- FSM states: IDLE, RUN, LAST. All outputs are registered.
- IDLE, start=1 at an edge:
  - latch div_l=div and burst_l=burst;
  - pc<=0, strobe_cnt<=0;
  - enable<=1, busy<=1, state<=RUN.
- start is ignored outside IDLE. abort is ignored in IDLE. done<=0 at every edge except the LAST->IDLE edge.
- RUN, each edge:
  - if pc==div_l: pc<=0, T<=1, strobe_cnt<=strobe_cnt+1;
  - else: pc<=pc+1, T<=0.
- First T pulse: high in the cycle following edge (start edge)+div_l+1, i.e. div_l+1 cycles after enable rises. With div_l=0, T is high every RUN cycle.
- Burst termination: if burst_l!=0 and the pulse being issued makes strobe_cnt+1==burst_l, then state<=LAST at that same edge. During LAST, T=1 and enable=1 hold for exactly one cycle, so the downstream stage captures the final pulse.
- LAST, next edge: T<=0, enable<=0, busy<=0, done<=1, state<=IDLE. done falls on the following edge.
- Continuous mode (burst_l==0): never enters LAST. strobe_cnt wraps modulo 2^CNT_W (255 -> 0 for CNT_W=8).
- Abort (RUN or LAST): next edge state<=IDLE, enable<=0, T<=0, busy<=0, pc<=0. done stays 0 and strobe_cnt holds its value.
  - abort has priority over pulse issue and over the LAST transition in the same cycle.
  - Abort in LAST does not cancel the T pulse already presented during that cycle.
- strobe_cnt holds after completion or abort until the next accepted start.
- Changes to div and burst while busy have no effect.

Test Plan:
- Reset check: assert reset with no clock edge -> enable=0, T=0, busy=0, done=0, strobe_cnt=0 immediately. Deassert reset with start=0 -> all outputs stay 0.
- div=0, burst=3, start pulsed at edge E0:
  - enable=1 and busy=1 after E0;
  - T high after E1, E2, E3; strobe_cnt reaches 3 at E3;
  - after E4: T=0, enable=0, busy=0, done=1; done=0 after E5;
  - downstream T flip-flop Q (reset 0) ends at 1.
- div=3, burst=2, start at E0 -> T high only in the cycles after E4 and E8, done=1 after E9, strobe_cnt=2; downstream Q returns to 0.
- div=1, burst=0 (continuous) -> T alternates every cycle, never done, busy stays 1; strobe_cnt goes 255 -> 0 on the 256th pulse.
- div=4, burst=10, abort after strobe_cnt=2, with start also asserted -> next edge: enable=0, T=0, busy=0, done never asserts, strobe_cnt holds at 2; the start asserted while busy is not accepted.
- Asynchronous reset mid-RUN (div=2, burst=5, after 1 pulse) -> outputs clear immediately. Deassert reset, then start with div=0, burst=1 -> exactly one T pulse, then done.
